// File: rtl/requant_package.sv
// Shared types and width constants for the MAC requantization stage.
// Control/flag structs and the FSM state type live here so the bench can use them too.
package requant_package;

    localparam int DATA_WIDTH      = 32;
    localparam int OUT_WIDTH       = 8;
    localparam int PACK            = 4;
    localparam int REQUANT_CNT_LEN = 65536;
    localparam int CNT_WIDTH       = 17;
    localparam int PROD_WIDTH      = 48;

    typedef struct packed {
        logic                  enable;
        logic                  clear;
        logic                  start;
        logic [CNT_WIDTH-1:0]  len;
        logic signed [15:0]    scale;
        logic [4:0]            shift;
        logic                  relu;
    } ctrl_requant_t;

    typedef struct packed {
        logic [CNT_WIDTH-1:0]  cnt;
        logic                  busy;
        logic                  done;
        logic                  sat;
    } flags_requant_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } requant_state_t;

endpackage

// File: rtl/mac_requant_sat.sv
// Round-half-up, arithmetic shift, optional ReLU and clamp of a 48b product to int8.
// sat_o flags only the clamp; ReLU zeroing is an intended transform, not saturation.
module mac_requant_sat
    import requant_package::*;
(
    input  logic signed [PROD_WIDTH-1:0] prod_i,
    input  logic [4:0]                   shift_i,
    input  logic                         relu_i,
    output logic [OUT_WIDTH-1:0]         res_o,
    output logic                         sat_o
);

    logic signed [PROD_WIDTH:0] rounded;
    logic signed [PROD_WIDTH:0] shifted;

    always_comb begin
        rounded = {prod_i[PROD_WIDTH-1], prod_i};
        if (shift_i != 5'd0) begin
            rounded = rounded + ((PROD_WIDTH+1)'(1) << (shift_i - 5'd1));
        end
        shifted = rounded >>> shift_i;
        if (relu_i && shifted[PROD_WIDTH]) begin
            shifted = '0;
        end
        res_o = shifted[OUT_WIDTH-1:0];
        sat_o = 1'b0;
        if (shifted > 49'sd127) begin
            res_o = 8'h7F;
            sat_o = 1'b1;
        end else if (shifted < -49'sd128) begin
            res_o = 8'h80;
            sat_o = 1'b1;
        end
    end

endmodule

// File: rtl/mac_requant.sv
// Requantizes a stream of 32b accumulator results to int8 and packs four per output word.
// state | meaning: IDLE = waiting for start | RUN = accepting inputs | DRAIN = flushing S1 and last word
module mac_requant
    import requant_package::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] d_data_i,
    input  logic                  d_valid_i,
    output logic                  d_ready_o,
    output logic [DATA_WIDTH-1:0] q_data_o,
    output logic [PACK-1:0]       q_strb_o,
    output logic                  q_valid_o,
    input  logic                  q_ready_i,
    input  ctrl_requant_t         ctrl_i,
    output flags_requant_t        flags_o
);

    requant_state_t              state_q;
    logic [CNT_WIDTH-1:0]        cnt_q;
    logic [1:0]                  lane_q;
    logic signed [PROD_WIDTH-1:0] prod_q;
    logic                        prod_valid_q;
    logic [DATA_WIDTH-1:0]       word_q, word_d;
    logic [PACK-1:0]             strb_q, strb_d;
    logic                        word_valid_q;
    logic                        sat_q;
    logic                        done_q;

    logic                        s1_adv, d_hs, q_hs, last_elem, sat_s2;
    logic [OUT_WIDTH-1:0]        res_s2;
    logic signed [PROD_WIDTH-1:0] d_ext, scale_ext, prod_d;

    mac_requant_sat u_sat (
        .prod_i  (prod_q),
        .shift_i (ctrl_i.shift),
        .relu_i  (ctrl_i.relu),
        .res_o   (res_s2),
        .sat_o   (sat_s2)
    );

    // S1 may only retire into the word register once the previous word is gone or leaving.
    assign s1_adv    = prod_valid_q & (~word_valid_q | q_ready_i);
    assign d_ready_o = ctrl_i.enable & ~ctrl_i.clear & ~rst_i & (state_q == RUN)
                       & (cnt_q < ctrl_i.len) & (~prod_valid_q | s1_adv);
    assign d_hs      = d_valid_i & d_ready_o;
    assign q_valid_o = ctrl_i.enable & word_valid_q;
    assign q_hs      = q_valid_o & q_ready_i;
    assign last_elem = (cnt_q == ctrl_i.len);

    assign d_ext     = {{(PROD_WIDTH-DATA_WIDTH){d_data_i[DATA_WIDTH-1]}}, d_data_i};
    assign scale_ext = {{(PROD_WIDTH-16){ctrl_i.scale[15]}}, ctrl_i.scale};
    assign prod_d    = d_ext * scale_ext;

    always_comb begin
        word_d = word_valid_q ? '0 : word_q;
        strb_d = word_valid_q ? '0 : strb_q;
        word_d[{lane_q, 3'b000} +: OUT_WIDTH] = res_s2;
        strb_d[lane_q] = 1'b1;
    end

    assign q_data_o      = word_q;
    assign q_strb_o      = strb_q;
    assign flags_o.cnt   = cnt_q;
    assign flags_o.busy  = (state_q != IDLE);
    assign flags_o.done  = done_q;
    assign flags_o.sat   = sat_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || ctrl_i.clear) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            lane_q       <= '0;
            prod_q       <= '0;
            prod_valid_q <= 1'b0;
            word_q       <= '0;
            strb_q       <= '0;
            word_valid_q <= 1'b0;
            sat_q        <= 1'b0;
            done_q       <= 1'b0;
        end else if (ctrl_i.enable) begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ctrl_i.start) begin
                        if (ctrl_i.len == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= RUN;
                            cnt_q   <= '0;
                            lane_q  <= '0;
                        end
                    end
                end
                RUN: begin
                    if (cnt_q == ctrl_i.len) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (!prod_valid_q && !word_valid_q) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (d_hs) begin
                prod_q       <= prod_d;
                prod_valid_q <= 1'b1;
                cnt_q        <= cnt_q + 1'b1;
            end else if (s1_adv) begin
                prod_valid_q <= 1'b0;
            end

            if (s1_adv) begin
                word_q       <= word_d;
                strb_q       <= strb_d;
                word_valid_q <= (lane_q == 2'd3) | last_elem;
                lane_q       <= last_elem ? 2'd0 : lane_q + 2'd1;
                sat_q        <= sat_q | sat_s2;
            end else if (q_hs) begin
                word_q       <= '0;
                strb_q       <= '0;
                word_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mac_requant.sv
// Directed and randomized checks of mac_requant against an arithmetic reference model.
module tb_mac_requant;
    import requant_package::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [DATA_WIDTH-1:0] d_data;
    logic                  d_valid;
    logic                  d_ready;
    logic [DATA_WIDTH-1:0] q_data;
    logic [PACK-1:0]       q_strb;
    logic                  q_valid;
    logic                  q_ready;
    ctrl_requant_t         ctrl;
    flags_requant_t        flags;

    int total = 0;
    int bad   = 0;
    int in_q[$];
    logic [31:0] wq[$];
    logic [3:0]  sq[$];
    bit sat_model = 1'b0;

    always #5 clk = ~clk;

    mac_requant dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .d_data_i  (d_data),
        .d_valid_i (d_valid),
        .d_ready_o (d_ready),
        .q_data_o  (q_data),
        .q_strb_o  (q_strb),
        .q_valid_o (q_valid),
        .q_ready_i (q_ready),
        .ctrl_i    (ctrl),
        .flags_o   (flags)
    );

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: product, round-half-up, shift, relu, clamp -- plain integer arithmetic.
    function automatic logic [7:0] ref_q(input int x, input int scale, input int shift,
                                         input bit relu, output bit s);
        longint p;
        logic [63:0] r;
        p = longint'(x) * longint'(scale);
        if (shift > 0) p = p + (longint'(1) << (shift - 1));
        p = p >>> shift;
        if (relu && p < 0) p = 0;
        s = 1'b0;
        if (p > 127) begin p = 127; s = 1'b1; end
        else if (p < -128) begin p = -128; s = 1'b1; end
        r = p;
        return r[7:0];
    endfunction

    task automatic build_expected(input int scale, input int shift, input bit relu);
        logic [31:0] w;
        logic [3:0]  st;
        bit s;
        logic [7:0] b;
        wq.delete();
        sq.delete();
        w = '0; st = '0;
        for (int i = 0; i < in_q.size(); i++) begin
            b = ref_q(in_q[i], scale, shift, relu, s);
            sat_model = sat_model | s;
            w[(i % 4) * 8 +: 8] = b;
            st[i % 4] = 1'b1;
            if ((i % 4) == 3 || i == in_q.size() - 1) begin
                wq.push_back(w);
                sq.push_back(st);
                w = '0; st = '0;
            end
        end
    endtask

    // mode 0: full rate, 1: random gaps/backpressure/enable, 2: 5-cycle stall after first word
    task automatic run_job(input string name, input int scale, input int shift,
                           input bit relu, input int mode);
        int len, idx, got, stall, first_word, fourth;
        bit done_seen, prev_hold, ready_fell;
        logic [31:0] prev_data;
        logic [3:0]  prev_strb;
        len = in_q.size();
        build_expected(scale, shift, relu);
        @(negedge clk);
        ctrl.enable = 1'b1;
        ctrl.len    = 17'(len);
        ctrl.scale  = 16'(scale);
        ctrl.shift  = 5'(shift);
        ctrl.relu   = relu;
        ctrl.start  = 1'b1;
        d_valid = 1'b0;
        q_ready = 1'b1;
        @(negedge clk);
        ctrl.start = 1'b0;
        idx = 0; got = 0; stall = 0; first_word = -1; fourth = -1;
        done_seen = 0; prev_hold = 0; ready_fell = 0;
        prev_data = '0; prev_strb = '0;
        for (int cyc = 0; cyc < 3000 && !done_seen; cyc++) begin
            ctrl.enable = (mode == 1) ? ($urandom_range(0, 7) != 0) : 1'b1;
            d_valid = (idx < len) && (mode != 1 || $urandom_range(0, 3) != 0);
            d_data  = d_valid ? in_q[idx] : $urandom;
            if (mode == 1) q_ready = ($urandom_range(0, 2) != 0);
            else           q_ready = (stall == 0);
            #1;
            if (!ctrl.enable) begin
                check({name, "_en0_dready"}, d_ready, 0);
                check({name, "_en0_qvalid"}, q_valid, 0);
            end
            if (prev_hold && q_valid) begin
                check({name, "_hold_data"}, q_data, prev_data);
                check({name, "_hold_strb"}, q_strb, prev_strb);
            end
            if (stall > 0 && !d_ready) ready_fell = 1;
            if (q_valid && first_word < 0) first_word = cyc;
            if (d_valid && d_ready) begin
                if (idx == 3) fourth = cyc;
                idx++;
            end
            if (q_valid && q_ready) begin
                if (got < wq.size()) begin
                    check({name, "_word"}, q_data, wq[got]);
                    check({name, "_strb"}, q_strb, sq[got]);
                end else begin
                    check({name, "_word_count"}, got + 1, wq.size());
                end
                got++;
                if (mode == 2 && got == 1) stall = 5;
            end else if (stall > 0 && !q_ready) begin
                stall--;
            end
            prev_hold = q_valid && !q_ready;
            prev_data = q_data;
            prev_strb = q_strb;
            if (flags.done) done_seen = 1;
            @(negedge clk);
        end
        check({name, "_done_seen"}, done_seen, 1);
        check({name, "_words"}, got, wq.size());
        check({name, "_cnt"}, flags.cnt, len);
        check({name, "_sat"}, flags.sat, sat_model);
        if (mode != 1) begin
            check({name, "_busy"}, flags.busy, 0);
            check({name, "_done_width"}, flags.done, 0);
        end
        if (mode == 0 && len >= 4) check({name, "_latency"}, first_word - fourth, 2);
        if (mode == 2) check({name, "_ready_fell"}, ready_fell, 1);
        ctrl.enable = 1'b1;
        d_valid = 1'b0;
        q_ready = 1'b1;
    endtask

    initial begin
        int n;
        int len;
        rst = 1'b1;
        ctrl = '0;
        ctrl.enable = 1'b1;
        d_valid = 1'b0;
        d_data = '0;
        q_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_flags", flags, 0);
        check("reset_qvalid", q_valid, 0);
        check("reset_dready", d_ready, 0);
        rst = 1'b0;

        in_q = '{1, 2, 3, 4};
        run_job("basic", 1, 0, 1'b0, 0);

        in_q = '{-3, 1000};
        run_job("round_sat", 1, 1, 1'b0, 0);

        in_q = '{-5, 4, 6, 8, 10, 12};
        run_job("relu", 2, 2, 1'b1, 0);

        in_q = '{1, 2, 3, 4, 5, 6, 7, 8};
        run_job("stall", 1, 0, 1'b0, 2);

        // start with len 0: done one cycle later, no output
        @(negedge clk);
        ctrl.len = '0;
        ctrl.start = 1'b1;
        @(negedge clk);
        ctrl.start = 1'b0;
        check("len0_done", flags.done, 1);
        check("len0_qvalid", q_valid, 0);
        check("len0_busy", flags.busy, 0);
        @(negedge clk);
        check("len0_done_drop", flags.done, 0);
        check("len0_qvalid2", q_valid, 0);

        // reset mid-operation
        ctrl.len = 17'd4; ctrl.scale = 16'd1; ctrl.shift = '0; ctrl.relu = 1'b0;
        ctrl.start = 1'b1;
        @(negedge clk);
        ctrl.start = 1'b0;
        n = 0;
        for (int c = 0; c < 20 && n < 2; c++) begin
            d_valid = 1'b1;
            d_data = 32'(n + 1);
            #1;
            if (d_ready) n++;
            @(negedge clk);
        end
        d_valid = 1'b0;
        check("midrst_cnt", flags.cnt, 2);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_flags", flags, 0);
        check("midrst_qvalid", q_valid, 0);
        rst = 1'b0;
        sat_model = 1'b0;
        @(negedge clk);
        check("postrst_qvalid", q_valid, 0);
        check("postrst_flags", flags, 0);
        in_q = '{1, 2, 3, 4};
        run_job("restart", 1, 0, 1'b0, 0);

        for (int j = 0; j < 5; j++) begin
            len = $urandom_range(1, 13);
            in_q.delete();
            for (int i = 0; i < len; i++) in_q.push_back(int'($urandom));
            run_job("rand", int'($urandom_range(0, 65535)) - 32768,
                    $urandom_range(0, 20), 1'($urandom_range(0, 1)), 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mac_requant.md
MAC_REQUANT -- requirements
Module: mac_requant

Interface
REQ-001 SHALL have no module parameters; widths come from package constants (DATA_WIDTH 32, OUT_WIDTH 8, PACK 4, REQUANT_CNT_LEN 65536).
REQ-002 SHALL have one clock and synchronous active-high reset: clk_i  in  1  rising-edge clock.
REQ-003 rst_i  in  1  synchronous, active-high reset.
REQ-004 d_i  hwpe_stream_intf_stream.sink  32  signed accumulator results from mac_engine d_o.
REQ-005 q_o  hwpe_stream_intf_stream.source  32  four packed signed 8b results, strb 4b.
REQ-006 ctrl_i  in  ctrl_requant_t  enable, clear, start, len[16:0], scale[15:0] signed, shift[4:0], relu.
REQ-007 flags_o  out  flags_requant_t  cnt[16:0], busy, done, sat.

Function
REQ-008 FSM states IDLE, RUN, DRAIN; IDLE->RUN on start (len>0); RUN->DRAIN when cnt==len; DRAIN->IDLE when pipeline empty and last word handshaken; done pulses 1 cycle on DRAIN->IDLE.
REQ-009 start with len==0 in IDLE: no output, done pulses next cycle, stays IDLE.
REQ-010 start while RUN/DRAIN ignored.
REQ-011 d_i.ready only in RUN with enable=1, cnt<len, and S1 free or advancing; d_i.ready=0 otherwise.
REQ-012 S1: on d_i handshake r_prod <= d_i.data * scale (signed, 48b), r_prod_valid set, cnt increments.
REQ-013 S2 (combinational from r_prod): add 1<<(shift-1) if shift>0, arithmetic shift right by shift, if relu and negative ->0, clamp to [-128,127]; sat sticky-set whenever clamp alters value.
REQ-014 S2 result written to lane lane_cnt of r_word (lane 0 = bits 7:0); lane_cnt wraps 3->0.
REQ-015 r_word_valid set when lane 3 written or when last element (cnt==len, S1 empty afterward) written; strb = one bit per filled lane, unfilled lanes 0x00.
REQ-016 q_o.data=r_word, q_o.strb=r_strb, q_o.valid=enable & r_word_valid; data/strb stable until handshake.
REQ-017 S1 advances into r_word only if ~r_word_valid or q_o.ready; ready propagates combinationally backward; no data lost or duplicated under backpressure.
REQ-018 Latency: handshake of 4th input at cycle t -> q_o.valid at t+2 with no backpressure; throughput 1 input/cycle.
REQ-019 r_word written and handshaken same cycle: handshake retires old word, new lane 0 write starts fresh word.
REQ-020 enable=0: all state frozen, d_i.ready=0, q_o.valid=0.
REQ-021 clear=1: same effect as reset (lower priority than rst_i, higher than enable).
REQ-022 busy=1 in RUN/DRAIN; flags_o.cnt = accepted-input count.

Reset
REQ-023 On rst_i: state IDLE, cnt 0, lane_cnt 0, r_prod/r_word/r_strb 0, both valids 0, sat 0, done 0, busy 0.
REQ-024 Reset mid-operation SHALL discard partial word; no q_o.valid in cycle after reset release.

Structure
REQ-025 requant_package SHALL hold ctrl_requant_t, flags_requant_t, state enum requant_state_t, DATA_WIDTH, OUT_WIDTH, PACK, REQUANT_CNT_LEN.
REQ-026 Round/ReLU/clamp SHALL be combinational sub-module mac_requant_sat (48b in, 8b out, sat out).

Verification
REQ-027 len=4, scale=1, shift=0, inputs 1,2,3,4 -> one word 0x04030201, strb 0xF, done pulse.
REQ-028 len=2, scale=1, shift=1, inputs -3, 1000 -> lanes 0xFF (rounds to -1), 0x7F; word 0x00007FFF, strb 0x3, sat=1.
REQ-029 len=6, relu=1, scale=2, shift=2, inputs -5,4,6,8,10,12 -> words 0x04030200 strb 0xF, then 0x00000605 strb 0x3.
REQ-030 len=8 streaming, q_o.ready low 5 cycles after first word -> d_i.ready falls, second word unchanged on release, exactly 2 words.
REQ-031 start with len=0 -> no q_o.valid, done high exactly 1 cycle later.
REQ-032 rst_i asserted after 2 of 4 inputs -> all flags 0, no output; restart len=4 inputs 1..4 -> 0x04030201.
